// File: rtl/writeback_queue_stage_if.sv
// Bundle of the retire-queue handshakes: execute-side entry, memory load response, register-file write.
// Latency: none, wiring only.
// Backpressure: stall_prev/next_stall/load_resp_ready travel against the data direction.
interface writeback_queue_stage_if #(
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
);
    localparam int REG_W = $clog2(NUM_REGISTERS);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // execute side
    logic                  prev_done;
    logic                  stall_prev;
    logic [ADDR_WIDTH-1:0] program_count_in;
    logic                  program_count_valid_in;
    logic                  load_in;
    logic                  store_in;
    logic                  opcode_legal_in;
    logic [1:0]            load_size_in;
    logic                  load_unsigned_in;
    logic [REG_W-1:0]      write_register_in;
    logic                  writeback_enabled_in;
    logic [DATA_WIDTH-1:0] result_data_in;
    // memory response
    logic                  load_resp_valid;
    logic [31:0]           load_resp_data;
    logic                  load_resp_ready;
    // retire side
    logic                  next_stall;
    logic                  done_next;
    logic [REG_W-1:0]      write_register;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_activate;
    logic                  illegal_retire;
    logic [ADDR_WIDTH-1:0] program_count_out;
    logic                  program_count_valid_out;
    logic [OCC_W-1:0]      occupancy;

    modport master (
        output prev_done, program_count_in, program_count_valid_in, load_in, store_in,
               opcode_legal_in, load_size_in, load_unsigned_in, write_register_in,
               writeback_enabled_in, result_data_in, load_resp_valid, load_resp_data, next_stall,
        input  stall_prev, load_resp_ready, done_next, write_register, write_data,
               write_activate, illegal_retire, program_count_out, program_count_valid_out, occupancy
    );

    modport slave (
        input  prev_done, program_count_in, program_count_valid_in, load_in, store_in,
               opcode_legal_in, load_size_in, load_unsigned_in, write_register_in,
               writeback_enabled_in, result_data_in, load_resp_valid, load_resp_data, next_stall,
        output stall_prev, load_resp_ready, done_next, write_register, write_data,
               write_activate, illegal_retire, program_count_out, program_count_valid_out, occupancy
    );
endinterface

// File: rtl/writeback_queue_stage.sv
// In-order retire queue between execute and the register file; a legal load waits at the head for its memory word.
// Latency: non-load entry retire-ready the cycle after acceptance; a load the cycle after its response is captured.
// Backpressure: stall_prev while full unless the head retires this cycle; next_stall holds the head. Option: WB_RETIRE_COUNT_EN adds instret_count.
module writeback_queue_stage #(
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    writeback_queue_stage_if.slave wb
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0]            instret_count
`endif
);
    localparam int REG_W = $clog2(NUM_REGISTERS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pc_vld;
        logic                  load;
        logic                  store;
        logic                  legal;
        logic [1:0]            size;
        logic                  uns;
        logic [REG_W-1:0]      rd;
        logic                  wb_en;
        logic [DATA_WIDTH-1:0] dat;   // ALU result, or effective address until a load is captured
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           entry_in;
    entry_t           head;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             head_loaded_q;

    logic             not_empty, full, head_wait_load;
    logic             transfer_next, transfer_prev, capture;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_ext;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign entry_in = '{
        pc:     wb.program_count_in,
        pc_vld: wb.program_count_valid_in,
        load:   wb.load_in,
        store:  wb.store_in,
        legal:  wb.opcode_legal_in,
        size:   wb.load_size_in,
        uns:    wb.load_unsigned_in,
        rd:     wb.write_register_in,
        wb_en:  wb.writeback_enabled_in,
        dat:    wb.result_data_in
    };

    assign head           = ent_q[head_q];
    assign not_empty      = (count_q != '0);
    assign full           = (count_q == CNT_W'(DEPTH));
    // Illegal entries never fetch data, even when flagged as loads.
    assign head_wait_load = head.load && head.legal;

    assign wb.done_next       = not_empty && (!head_wait_load || head_loaded_q);
    assign transfer_next      = wb.done_next && !wb.next_stall;
    assign wb.stall_prev      = !rst_n || (full && !transfer_next);
    assign transfer_prev      = wb.prev_done && !wb.stall_prev;
    assign wb.load_resp_ready = not_empty && head_wait_load && !head_loaded_q;
    assign capture            = wb.load_resp_ready && wb.load_resp_valid;

    assign wb.write_activate = transfer_next && head.legal && !head.store && head.wb_en && (head.rd != '0);
    assign wb.illegal_retire = transfer_next && !head.legal;
    // Payload is not reset, so head-derived buses are forced to zero while in reset.
    assign wb.write_register          = rst_n ? head.rd  : '0;
    assign wb.write_data              = rst_n ? head.dat : '0;
    assign wb.program_count_out       = rst_n ? head.pc  : '0;
    assign wb.program_count_valid_out = not_empty && head.pc_vld;
    assign wb.occupancy               = count_q;

    // Select and extend the loaded byte/half/word using the low address bits held at the head.
    always_comb begin
        byte_sel = 8'(wb.load_resp_data >> {head.dat[1:0], 3'b000});
        half_sel = 16'(wb.load_resp_data >> {head.dat[1], 4'b0000});
        load_ext = wb.load_resp_data;
        case (head.size)
            2'd0:    load_ext = {{24{!head.uns && byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{!head.uns && half_sel[15]}}, half_sel};
            default: load_ext = wb.load_resp_data;
        endcase
    end

    // Pointer, occupancy and head-loaded bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            head_loaded_q <= 1'b0;
        end else begin
            if (transfer_prev) tail_q <= ptr_inc(tail_q);
            if (transfer_next) head_q <= ptr_inc(head_q);
            case ({transfer_prev, transfer_next})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (transfer_next)
                head_loaded_q <= 1'b0;
            else if (capture)
                head_loaded_q <= 1'b1;
        end
    end

    // Entry payload: push at tail, load data overwrites the head's address field.
    // A capture and a push never target the same slot (a full queue only accepts while the head retires).
    always_ff @(posedge clk) begin
        if (capture) ent_q[head_q].dat <= DATA_WIDTH'(load_ext);
        if (transfer_prev) ent_q[tail_q] <= entry_in;
    end

`ifdef WB_RETIRE_COUNT_EN
    // Retired-instruction counter, illegal entries included; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_count <= '0;
        else if (transfer_next)
            instret_count <= instret_count + 64'd1;
    end
`endif
endmodule

// File: tb/tb_writeback_queue_stage.sv
// Randomized and directed bench for writeback_queue_stage against a queue-based reference model.
// Latency: model advances once per clock; outputs checked 1 ns after the falling edge.
// Backpressure: next_stall and load_resp_valid are randomized to exercise stall paths.
module tb_writeback_queue_stage;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_stage_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGISTERS(32)) wbif ();

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] instret_count;
`endif

    writeback_queue_stage #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGISTERS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbif)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .instret_count (instret_count)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        pcv;
        logic        ld;
        logic        st;
        logic        legal;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  rd;
        logic        wben;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_loaded  = 1'b0;
    logic [63:0] m_instret = '0;
    int n_cmp = 0;
    int n_bad = 0;
    int illegal_seen = 0;
    int writes_seen  = 0;
    int occ_max      = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load result from the rules: pick byte/half by address, then extend.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> ((off >= 2'd2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic set_entry(input logic [31:0] pc, input logic ld, input logic st, input logic legal,
                             input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                             input logic wben, input logic [31:0] data);
        wbif.prev_done              = 1'b1;
        wbif.program_count_in       = pc;
        wbif.program_count_valid_in = 1'b1;
        wbif.load_in                = ld;
        wbif.store_in               = st;
        wbif.opcode_legal_in        = legal;
        wbif.load_size_in           = sz;
        wbif.load_unsigned_in       = uns;
        wbif.write_register_in      = rd;
        wbif.writeback_enabled_in   = wben;
        wbif.result_data_in         = data;
    endtask

    // One clock: check outputs against the model, then advance the model at the rising edge.
    task automatic step();
        ent_t h, inc;
        int cnt;
        logic hld, done, tn, stall, lrr, wa, capt, push;
        logic [31:0] resp;
        #1;
        cnt = mq.size();
        h   = '0;
        if (cnt != 0) h = mq[0];
        hld   = (cnt != 0) && h.ld && h.legal;
        done  = (cnt != 0) && (!hld || m_loaded);
        tn    = done && !wbif.next_stall;
        stall = (cnt == DEPTH) && !tn;
        lrr   = hld && !m_loaded;
        wa    = tn && h.legal && !h.st && h.wben && (h.rd != 5'd0);
        capt  = lrr && wbif.load_resp_valid;
        push  = wbif.prev_done && !stall;
        resp  = wbif.load_resp_data;
        chk("done_next", wbif.done_next, done);
        chk("stall_prev", wbif.stall_prev, stall);
        chk("load_resp_ready", wbif.load_resp_ready, lrr);
        chk("write_activate", wbif.write_activate, wa);
        chk("illegal_retire", wbif.illegal_retire, tn && !h.legal);
        chk("occupancy", wbif.occupancy, cnt);
        chk("pc_valid_out", wbif.program_count_valid_out, (cnt != 0) && h.pcv);
        if (cnt != 0) chk("pc_out", wbif.program_count_out, h.pc);
        if (wa) begin
            chk("write_register", wbif.write_register, h.rd);
            chk("write_data", wbif.write_data, h.data);
        end
`ifdef WB_RETIRE_COUNT_EN
        chk("instret_count", instret_count, m_instret);
`endif
        if (wbif.illegal_retire) illegal_seen++;
        if (wbif.write_activate) writes_seen++;
        if (int'(wbif.occupancy) > occ_max) occ_max = int'(wbif.occupancy);
        inc = '{pc: wbif.program_count_in, pcv: wbif.program_count_valid_in, ld: wbif.load_in,
                st: wbif.store_in, legal: wbif.opcode_legal_in, sz: wbif.load_size_in,
                uns: wbif.load_unsigned_in, rd: wbif.write_register_in,
                wben: wbif.writeback_enabled_in, data: wbif.result_data_in};
        @(posedge clk);
        if (capt) begin
            h.data   = extract(resp, h.data[1:0], h.sz, h.uns);
            mq[0]    = h;
            m_loaded = 1'b1;
        end
        if (tn) begin
            void'(mq.pop_front());
            m_loaded  = 1'b0;
            m_instret = m_instret + 64'd1;
        end
        if (push) mq.push_back(inc);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        wbif.prev_done = 1'b0;
        set_entry('0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, '0);
        wbif.prev_done       = 1'b0;
        wbif.next_stall      = 1'b0;
        wbif.load_resp_valid = 1'b0;
        wbif.load_resp_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall_prev", wbif.stall_prev, 1'b1);
        chk("rst_occupancy", wbif.occupancy, 0);
        chk("rst_done_next", wbif.done_next, 1'b0);
        chk("rst_write_data", wbif.write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1) four ALU entries back to back, no backpressure
        occ_max = 0; writes_seen = 0;
        for (int i = 0; i < 4; i++) begin
            set_entry(32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'(5 + i), 1'b1, 32'(32'h11 * (i + 1)));
            step();
        end
        wbif.prev_done = 1'b0;
        steps(3);
        chk("s1_occ_peak", occ_max, 1);
        chk("s1_writes", writes_seen, 4);

        // 2) downstream stalled, five pushes into a four-deep queue
        wbif.next_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_entry(32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'(10 + i), 1'b1, 32'(32'hA0 + i));
            step();
        end
        step();
        wbif.next_stall = 1'b0;
        step();
        wbif.prev_done = 1'b0;
        steps(6);

        // 3) lb at offset 3, then lhu at offset 2, same memory word
        set_entry(32'h300, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 5'd9, 1'b1, 32'h0000_1003);
        step();
        wbif.prev_done = 1'b0;
        step();
        wbif.load_resp_valid = 1'b1; wbif.load_resp_data = 32'h80FF_EE11;
        step();
        wbif.load_resp_valid = 1'b0;
        #1;
        chk("lb_we", wbif.write_activate, 1'b1);
        chk("lb_data", wbif.write_data, 32'hFFFF_FF80);
        step();
        set_entry(32'h304, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 5'd9, 1'b1, 32'h0000_2002);
        step();
        wbif.prev_done = 1'b0;
        wbif.load_resp_valid = 1'b1;
        step();
        wbif.load_resp_valid = 1'b0;
        #1;
        chk("lhu_data", wbif.write_data, 32'h0000_80FF);
        step();

        // 4) head load starved for 10 cycles with ALU entries queued behind it
        set_entry(32'h400, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd3, 1'b1, 32'h0000_4000);
        step();
        set_entry(32'h404, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd4, 1'b1, 32'h1234);
        step();
        set_entry(32'h408, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd6, 1'b1, 32'h5678);
        step();
        wbif.prev_done = 1'b0;
        steps(10);
        #1;
        chk("s4_occ_held", wbif.occupancy, 3);
        wbif.load_resp_valid = 1'b1; wbif.load_resp_data = 32'hCAFE_F00D;
        step();
        wbif.load_resp_valid = 1'b0;
        steps(4);

        // 5) rd=0 write suppressed, then an illegal entry flagged as a load
        illegal_seen = 0; writes_seen = 0;
        set_entry(32'h500, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b1, 32'hDEAD);
        step();
        set_entry(32'h504, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd7, 1'b1, 32'hBEEF);
        step();
        wbif.prev_done = 1'b0;
        steps(4);
        chk("s5_illegal_pulses", illegal_seen, 1);
        chk("s5_writes", writes_seen, 0);

        // 6) reset mid-stream with a pending head load and two entries behind it
        wbif.next_stall = 1'b1;
        set_entry(32'h600, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd1, 1'b1, 32'h0000_6000);
        step();
        set_entry(32'h604, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd2, 1'b1, 32'h66);
        step();
        set_entry(32'h608, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd3, 1'b1, 32'h77);
        step();
        wbif.prev_done = 1'b0;
        wbif.next_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_occupancy", wbif.occupancy, 0);
        chk("mrst_stall_prev", wbif.stall_prev, 1'b1);
        chk("mrst_done_next", wbif.done_next, 1'b0);
        chk("mrst_write_activate", wbif.write_activate, 1'b0);
        chk("mrst_load_resp_ready", wbif.load_resp_ready, 1'b0);
        mq.delete();
        m_loaded  = 1'b0;
        m_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_entry(32'h700, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd8, 1'b1, 32'h88);
        step();
        wbif.prev_done = 1'b0;
        steps(2);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            set_entry($urandom, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            wbif.program_count_valid_in = 1'($urandom_range(0, 1));
            wbif.prev_done       = ($urandom_range(0, 9) < 6);
            wbif.next_stall      = ($urandom_range(0, 3) == 0);
            wbif.load_resp_valid = ($urandom_range(0, 1) == 1);
            wbif.load_resp_data  = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
